sgbm_pixel_streamer: RTL
========================

SGBM_PIXEL_STREAMER -- requirements
Module: sgbm_pixel_streamer

Interface
REQ-001 Parameter IMG_ROW, default 200, frame height in pixels.
REQ-002 Parameter IMG_COL, default 400, frame width in pixels.
REQ-003 Parameter PIX_W, default 8, greyscale pixel width.
REQ-004 Parameter COORD_W, default 10, row/column coordinate width.
REQ-005 Parameter ADDR_W, default 17, linear pixel address width (holds IMG_ROW*IMG_COL-1).
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low.
REQ-008 start  in  1  one-cycle pulse; begins frame scan when idle.
REQ-009 cont_mode  in  1  1 = restart next frame automatically; sampled at start and at each frame end.
REQ-010 abort  in  1  stop scan, flush pipeline, return to IDLE.
REQ-011 mem_rd_en  out  1  read strobe to left and right image memories.
REQ-012 mem_addr  out  ADDR_W  linear address row*IMG_COL+col, shared by both memories.
REQ-013 left_rd_data / right_rd_data  in  PIX_W each  memory data, valid exactly 1 cycle after mem_rd_en.
REQ-014 grey_left / grey_right  out  PIX_W each  output pixel pair.
REQ-015 grey_row / grey_col  out  COORD_W each  coordinates of output pair.
REQ-016 sof / eol / eof  out  1 each  first pixel of frame / last of row / last of frame, qualified by valid.
REQ-017 valid  out  1  output pair valid.
REQ-018 ready  in  1  downstream accepts pair when valid&&ready.
REQ-019 busy  out  1  high in RUN or DRAIN.
REQ-020 frame_done  out  1  one-cycle pulse when eof pair is accepted.

Function
REQ-021 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after last address issued; DRAIN->RUN (cont_mode=1) or IDLE (cont_mode=0) when eof pair accepted.
REQ-022 Scan order SHALL be row-major: col 0..IMG_COL-1 within row, row 0..IMG_ROW-1; col wraps to 0 and row increments at col=IMG_COL-1.
REQ-023 mem_addr SHALL be produced by an incrementing counter (no multiplier), reset to 0 at each frame start.
REQ-024 Read SHALL be issued only when (in-flight reads + buffered pairs) < 2, guaranteeing no pair is lost under backpressure.
REQ-025 Returned data plus its coordinates/flags SHALL enter a 2-entry skid buffer; output comes from buffer head, in order.
REQ-026 With ready held high, latency start->first valid SHALL be 2 cycles and throughput one pair per cycle.
REQ-027 Outputs SHALL hold stable while valid&&!ready.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort SHALL take priority over all events: next cycle state=IDLE, buffer empty, in-flight read discarded, valid=0, no frame_done.
REQ-030 In continuous mode the first pair of the next frame SHALL follow the eof pair with no bubble when ready is high.
REQ-031 IMG_ROW=1 or IMG_COL=1 SHALL work: sof/eol/eof may coincide on one pair.

Reset
REQ-032 On rst low: state IDLE, counters 0, buffer empty, mem_rd_en=0, mem_addr=0, valid=0, sof=eol=eof=0, grey_*=0, grey_row=grey_col=0, busy=0, frame_done=0.
REQ-033 Reset mid-frame SHALL discard all pending data; first frame after release requires a new start.

Structure
REQ-034 Shared package sgbm_pkg SHALL hold the state enumeration and default IMG_ROW/IMG_COL/PIX_W/COORD_W constants.
REQ-035 The 2-entry skid buffer SHALL be sub-module sgbm_stream_skid, parametrised on payload width.

Verification
REQ-036 IMG_ROW=2, IMG_COL=3, ready=1, start -> 6 pairs on consecutive cycles from cycle 2, coords (0,0)..(1,2), eol at col 2, sof on first, eof+frame_done on (1,2).
REQ-037 Random ready (50%) over full 200x400 frame -> 80000 pairs, in-order, data matches memory model, none dropped or duplicated.
REQ-038 ready=0 for 10 cycles mid-row -> valid held, payload stable, at most 2 reads outstanding, resumes with next pixel.
REQ-039 cont_mode=1, 2x3 frame -> second sof immediately after first eof, mem_addr wraps to 0, busy stays high.
REQ-040 abort at pixel (1,1) -> valid=0 next cycle, state IDLE, no frame_done; new start restarts at (0,0).
REQ-041 rst low at pixel (0,2) -> all outputs zero asynchronously; start pulse during busy ignored.

Source files
------------

// File: rtl/sgbm_pkg.sv
// Shared types and default geometry for the SGBM pixel streamer.
package sgbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int IMG_ROW_DEF = 200;
  localparam int IMG_COL_DEF = 400;
  localparam int PIX_W_DEF   = 8;
  localparam int COORD_W_DEF = 10;
  localparam int ADDR_W_DEF  = 17;

endpackage

// File: rtl/sgbm_stream_skid.sv
// Two-entry in-order buffer holding returned pixel pairs until downstream takes them.
module sgbm_stream_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_slot0;
  logic [W-1:0] r_slot1;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  // The upstream read credit guarantees a push never arrives while both slots are full.
  assign w_pop = i_pop && (r_count != 2'd0);

  // Slot storage, pointers and occupancy; flush drops everything without touching slot data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot0  <= '0;
      r_slot1  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        if (r_wr_ptr) r_slot1 <= i_data;
        else          r_slot0 <= i_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(i_push) - 2'(w_pop);
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_rd_ptr ? r_slot1 : r_slot0;
  assign o_count = r_count;

endmodule

// File: rtl/sgbm_pixel_streamer.sv
// Row-major scanner that reads left/right image memories and streams pixel pairs
// with coordinates and frame markers under valid/ready flow control.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; address counters parked at 0
//   ST_RUN   | issuing reads for the current frame
//   ST_DRAIN | last address issued; waiting for the eof pair to be taken,
//            | prefetching the next frame when continuous mode is latched
module sgbm_pixel_streamer
  import sgbm_pkg::*;
#(
  parameter int IMG_ROW = IMG_ROW_DEF,
  parameter int IMG_COL = IMG_COL_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont_mode,
  input  logic               abort,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   left_rd_data,
  input  logic [PIX_W-1:0]   right_rd_data,
  output logic [PIX_W-1:0]   grey_left,
  output logic [PIX_W-1:0]   grey_right,
  output logic [COORD_W-1:0] grey_row,
  output logic [COORD_W-1:0] grey_col,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int PAY_W = 2*PIX_W + 2*COORD_W + 3;
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_ROW - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_COL - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_if_row;
  logic [COORD_W-1:0] r_if_col;
  logic               r_if_sof;
  logic               r_if_eol;
  logic               r_if_eof;
  logic               r_inflight;
  logic               r_cont;
  logic               w_rd_en;
  logic               w_last;
  logic               w_issue_ok;
  logic               w_pop;
  logic               w_eof_acc;
  logic               w_out_valid;
  logic [1:0]         w_count;
  logic [2:0]         w_occ;
  logic [PAY_W-1:0]   w_push_data;
  logic [PAY_W-1:0]   w_head;

  assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_pop  = w_out_valid && ready;
  // A slot freed by this cycle's pop may be reused, which keeps one pair per cycle flowing.
  assign w_occ      = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue_ok = (w_occ < 3'd2);
  assign w_eof_acc  = w_pop && w_head[0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and read strobe; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_rd_en     = 1'b1;
            w_state_nxt = w_last ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue_ok) begin
            w_rd_en = 1'b1;
            if (w_last) w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Prefetch of the next frame stops short of its last address so a
          // second frame end can never be pending while this one drains.
          if (r_cont && w_issue_ok && !w_last) w_rd_en = 1'b1;
          if (w_eof_acc) w_state_nxt = r_cont ? ST_RUN : ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Address/coordinate counters, in-flight tag and latched continuous-mode flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_if_row   <= '0;
      r_if_col   <= '0;
      r_if_sof   <= 1'b0;
      r_if_eol   <= 1'b0;
      r_if_eof   <= 1'b0;
      r_inflight <= 1'b0;
      r_cont     <= 1'b0;
    end else if (abort) begin
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_inflight <= 1'b0;
      r_cont     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_if_row <= r_row;
        r_if_col <= r_col;
        r_if_sof <= (r_row == '0) && (r_col == '0);
        r_if_eol <= (r_col == LAST_COL);
        r_if_eof <= w_last;
        if (w_last) begin
          r_addr <= '0;
          r_row  <= '0;
          r_col  <= '0;
          r_cont <= cont_mode;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + COORD_W'(1);
          end else begin
            r_col <= r_col + COORD_W'(1);
          end
        end
        if (r_state == ST_IDLE) r_cont <= cont_mode;
      end
    end
  end

  assign w_push_data = {left_rd_data, right_rd_data, r_if_row, r_if_col,
                        r_if_sof, r_if_eol, r_if_eof};

  sgbm_stream_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_flush (abort),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .i_pop   (ready),
    .o_valid (w_out_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign mem_rd_en  = w_rd_en;
  assign mem_addr   = r_addr;
  assign grey_left  = w_head[PAY_W-1 -: PIX_W];
  assign grey_right = w_head[PAY_W-PIX_W-1 -: PIX_W];
  assign grey_row   = w_head[2*COORD_W+2 -: COORD_W];
  assign grey_col   = w_head[COORD_W+2 -: COORD_W];
  assign sof        = w_head[2] && w_out_valid;
  assign eol        = w_head[1] && w_out_valid;
  assign eof        = w_head[0] && w_out_valid;
  assign valid      = w_out_valid;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = w_eof_acc && !abort;

endmodule
